// File: rtl/aes_pkg.sv
// Shared AES constants: state encoding, round count, S-box and Rcon tables.
package aes_pkg;

   localparam int AES_NR = 10;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Forward S-box, entry x at SBOX[x]; same table feeds SubBytes and SubWord.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Rcon[1..10] stored at RCON[0..9].
   localparam logic [0:9][7:0] RCON = {
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
      return SBOX[x];
   endfunction

   // Round constant for round i (1..10); zero outside that range.
   function automatic logic [7:0] rcon_lookup(input logic [3:0] i);
      logic [7:0] r;
      r = 8'h00;
      if (i >= 4'd1 && i <= 4'd10) begin
         r = RCON[i - 4'd1];
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Round-key stream bus between the key schedule and the AddRoundKey stage.
interface aes_key_expand_if;

   logic         start;
   logic [127:0] key;
   logic         key_ready;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         key_valid;
   logic         busy;
   logic         done;

   // Controller / round datapath side.
   modport master (
      output start, key, key_ready,
      input  round_key, round_idx, key_valid, busy, done
   );

   // Key schedule side.
   modport slave (
      input  start, key, key_ready,
      output round_key, round_idx, key_valid, busy, done
   );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] value,
   output logic [7:0] subst
);

   assign subst = sbox_lookup(value);

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per accepted handshake.
module aes_key_expand
   import aes_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   aes_key_expand_if.slave bus
);

   state_t       state;
   logic [127:0] key_reg;
   logic [3:0]   idx_reg;
   logic         valid_reg;
   logic         busy_reg;
   logic         done_reg;

   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  rot_word, sub_word, temp_word;
   logic [31:0]  n0, n1, n2, n3;
   logic [127:0] next_key;
   logic         handshake;

   assign w0 = key_reg[127:96];
   assign w1 = key_reg[95:64];
   assign w2 = key_reg[63:32];
   assign w3 = key_reg[31:0];

   assign rot_word = {w3[23:0], w3[31:24]};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_subword
         aes_sbox u_sbox (
            .value (rot_word[8*gi +: 8]),
            .subst (sub_word[8*gi +: 8])
         );
      end
   endgenerate

   assign temp_word = sub_word ^ {rcon_lookup(idx_reg + 4'd1), 24'h000000};
   assign n0        = w0 ^ temp_word;
   assign n1        = w1 ^ n0;
   assign n2        = w2 ^ n1;
   assign n3        = w3 ^ n2;
   assign next_key  = {n0, n1, n2, n3};

   assign handshake = valid_reg & bus.key_ready;

   // Schedule FSM: key register, round counter and registered status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         key_reg   <= '0;
         idx_reg   <= '0;
         valid_reg <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  key_reg   <= bus.key;
                  idx_reg   <= 4'd0;
                  valid_reg <= 1'b1;
                  busy_reg  <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (handshake) begin
                  if (idx_reg == 4'(AES_NR)) begin
                     valid_reg <= 1'b0;
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     key_reg <= next_key;
                     idx_reg <= idx_reg + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.round_key = key_reg;
   assign bus.round_idx = idx_reg;
   assign bus.key_valid = valid_reg;
   assign bus.busy      = busy_reg;
   assign bus.done      = done_reg;

endmodule
